// File: rtl/ysyx_220066_wb_arb.sv
// Write-back arbiter: merges NCH result channels, each with a one-entry holding
// register, into the single register-file write port and counts retired instructions.
module ysyx_220066_wb_arb #(
    parameter int NCH      = 3,
    parameter int XLEN     = 64,
    parameter int ARB_MODE = 0,
    parameter int LATE_CH  = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NCH-1:0]      in_valid,
    output logic [NCH-1:0]      in_ready,
    input  logic [NCH-1:0]      in_wen,
    input  logic [NCH-1:0]      in_late,
    input  logic [NCH-1:0]      in_error,
    input  logic [NCH*5-1:0]    in_rd,
    input  logic [NCH*XLEN-1:0] in_data,
    input  logic [NCH*XLEN-1:0] in_nxtpc,
    input  logic                late_valid,
    input  logic                late_error,
    input  logic [XLEN-1:0]     late_data,
    output logic                retire_valid,
    output logic                wen,
    output logic [4:0]          rd,
    output logic [XLEN-1:0]     data,
    output logic [XLEN-1:0]     nxtpc,
    output logic                error,
    output logic [NCH-1:0]      grant,
    output logic [63:0]         retire_cnt
);

    localparam int PW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [NCH-1:0] LATE_MASK = NCH'(1) << LATE_CH;

    logic [NCH-1:0]  hv;
    logic [NCH-1:0]  h_wen;
    logic [NCH-1:0]  h_late;
    logic [NCH-1:0]  h_err;
    logic [4:0]      h_rd   [NCH];
    logic [XLEN-1:0] h_data [NCH];
    logic [XLEN-1:0] h_pc   [NCH];

    logic [NCH-1:0]  late_eff;
    logic [NCH-1:0]  elig;
    logic [NCH-1:0]  cap;
    logic [PW-1:0]   ptr;
    logic [PW-1:0]   gidx;
    logic            found;

    // Only the designated late channel may wait for late_data; other late bits are masked.
    assign late_eff = h_late & LATE_MASK;
    assign elig     = hv & ~(late_eff & {NCH{~late_valid}});
    assign in_ready = {NCH{~rst}} & (~hv | grant);
    assign cap      = in_valid & in_ready;

    always_comb begin
        int j;
        j     = 0;
        found = 1'b0;
        gidx  = '0;
        for (int k = 0; k < NCH; k++) begin
            j = (ARB_MODE == 1) ? int'(ptr) + k : k;
            if (j >= NCH) begin
                j = j - NCH;
            end
            if (!found && elig[j]) begin
                found = 1'b1;
                gidx  = PW'(j);
            end
        end
    end

    assign grant        = found ? (NCH'(1) << gidx) : '0;
    assign retire_valid = found;

    always_comb begin
        wen   = 1'b0;
        rd    = '0;
        data  = '0;
        nxtpc = '0;
        error = 1'b0;
        if (found) begin
            rd    = h_rd[gidx];
            nxtpc = h_pc[gidx];
            data  = late_eff[gidx] ? late_data : h_data[gidx];
            error = h_err[gidx] | (late_eff[gidx] & late_error);
            wen   = h_wen[gidx] & (h_rd[gidx] != 5'd0);
        end
    end

    // A granted entry may be replaced by a new capture on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hv     <= '0;
            h_wen  <= '0;
            h_late <= '0;
            h_err  <= '0;
            for (int i = 0; i < NCH; i++) begin
                h_rd[i]   <= '0;
                h_data[i] <= '0;
                h_pc[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (cap[i]) begin
                    hv[i]     <= 1'b1;
                    h_wen[i]  <= in_wen[i];
                    h_late[i] <= in_late[i];
                    h_err[i]  <= in_error[i];
                    h_rd[i]   <= in_rd[i*5 +: 5];
                    h_data[i] <= in_data[i*XLEN +: XLEN];
                    h_pc[i]   <= in_nxtpc[i*XLEN +: XLEN];
                end else if (grant[i]) begin
                    hv[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr        <= '0;
            retire_cnt <= '0;
        end else if (found) begin
            ptr        <= (gidx == PW'(NCH - 1)) ? '0 : gidx + PW'(1);
            retire_cnt <= retire_cnt + 64'd1;
        end
    end

endmodule

// File: doc/ysyx_220066_wb_arb.md
# ysyx_220066_wb_arb

Parametrised write-back arbiter at the end of the ysyx_220066 pipeline. It merges NCH independent result channels (memory, multiplier, divider, and future units) into the single register-file write port. Each channel has a one-entry holding register with a valid/ready handshake. One channel can wait on late load data. Arbitration is fixed-priority or round-robin, and a retired-instruction counter is maintained.

## Interface
Parameters:
- NCH, 3: number of result channels (2..8); channel 0 is the memory channel by convention.
- XLEN, 64: data and PC width.
- ARB_MODE, 0: 0 = fixed priority (lowest index wins); 1 = round-robin.
- LATE_CH, 0: index of the channel whose entries may take their data from the late-data port.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  reset; asynchronous, active-high.
- in_valid  in  NCH  channel i presents a result.
- in_ready  out  NCH  channel i's holding register accepts this cycle.
- in_wen  in  NCH  result writes a register.
- in_late  in  NCH  result data arrives later on late_data; ignored for i != LATE_CH.
- in_error  in  NCH  result carries an exception/error.
- in_rd  in  NCH*5  destination register; slice i = bits [5i+4:5i].
- in_data  in  NCH*XLEN  result data.
- in_nxtpc  in  NCH*XLEN  next PC of the producing instruction.
- late_valid  in  1  late load data is valid this cycle.
- late_error  in  1  late load data faulted.
- late_data  in  XLEN  late load data.
- retire_valid  out  1  one instruction retires this cycle.
- wen  out  1  register-file write enable.
- rd  out  5  write address.
- data  out  XLEN  write data.
- nxtpc  out  XLEN  next PC of the retiring instruction.
- error  out  1  retiring instruction has an error.
- grant  out  NCH  one-hot retiring channel, or 0.
- retire_cnt  out  64  instructions retired since reset.

## Operation
- Per-channel holding register: hv[i] (valid flag), plus wen, late, error, rd, data, nxtpc.
- in_ready[i] = ~rst & (~hv[i] | grant[i]). Capture occurs when in_valid[i] & in_ready[i]; otherwise hv[i] clears when grant[i]. Capture and drain in the same cycle is allowed, giving 1 result/cycle/channel.
- Eligibility: elig[i] = hv[i] & ~(late[i] & ~late_valid). The late flag is honoured only for i == LATE_CH.
- Fixed priority: grant the lowest eligible index.
- Round-robin: pointer ptr (log2 NCH bits). Grant the first eligible index scanning ptr, ptr+1, ... mod NCH. On any grant g, ptr <= (g+1) mod NCH. ptr holds when there is no grant.
- At most one grant per cycle.
- retire_valid = |grant.
- Output mux selects the granted entry.
  - data = late_data when the entry is late, else the stored data.
  - error = stored error | (late & late_error).
  - wen = retire_valid & entry.wen & (rd != 0). An x0 write retires without asserting wen.
- Error entries still retire. Suppressing the write is the consumer's responsibility; the arbiter passes wen through unchanged.
- When there is no grant: wen, error, rd, data, nxtpc, grant are all 0.
- retire_cnt increments by 1 per retire_valid cycle and wraps modulo 2^64.

## Timing
- Reset (async, immediate): all hv = 0, ptr = 0, retire_cnt = 0. All outputs 0, including in_ready.
- First cycle after rst deasserts: in_ready = all ones.
- Latency: a result accepted at edge k appears on the outputs during cycle k+1 (combinational from the holding register). It retires at edge k+1 if granted.
- A late entry stalls only its own channel. Other eligible channels retire around it.
- late_valid with no late entry held is ignored.
- A non-granted entry holds all fields stable. in_ready[i] = 0 until it drains.
- Reset asserted mid-operation drops all held entries; nothing is retired for them.
- All outputs are combinational from state and late_* inputs. No combinational path from in_valid to any output except in_ready via grant (in_ready does not depend on in_valid).

## Test plan
- Reset, then a single result on ch1 (rd=5, data=0xAB, nxtpc=0x80000004) at edge 1 -> cycle 1: grant=3'b010, wen=1, rd=5, data=0xAB, nxtpc=0x80000004; retire_cnt=1 after edge 2.
- ARB_MODE=0, all three channels loaded at the same edge -> retire order ch0, ch1, ch2 on three consecutive cycles; in_ready[2]=0 for the first two.
- ARB_MODE=1, all channels continuously valid -> grants rotate 001, 010, 100, 001…; retire_cnt advances by 1 per cycle.
- ch0 late entry (rd=10) held with late_valid=0 for 3 cycles while ch1 retires -> ch0 not granted; then late_valid=1, late_data=0x1234, late_error=1 -> wen=1, rd=10, data=0x1234, error=1.
- Result with rd=0 and in_wen=1 -> retire_valid=1, wen=0, retire_cnt increments.
- rst pulsed asynchronously mid-cycle with entries held -> outputs and in_ready drop to 0 immediately; after release, no stale retirement, retire_cnt=0.
